// File: rtl/kl_mem_pkg.sv
// Shared definitions for the dual-core data-memory arbiter.
// Holds the address-map constants, the region enum used by the decoder and
// the read-source tags, and the address decode helper.
package kl_mem_pkg;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int NLOCK = 16;
    localparam logic [AW-1:0] LOCK_BASE = 9'h100;

    // One past the last lock address. It is one bit wider so the compare
    // cannot wrap.
    localparam logic [AW:0] LOCK_END = (AW+1)'(int'(LOCK_BASE) + NLOCK);

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_LOCK = 2'd1,
        REG_VOID = 2'd2
    } region_t;

    // RAM below LOCK_BASE, a lock window of NLOCK words, void above it.
    function automatic region_t decode_region(input logic [AW-1:0] addr);
        if (addr < LOCK_BASE)
            return REG_RAM;
        else if ({1'b0, addr} < LOCK_END)
            return REG_LOCK;
        else
            return REG_VOID;
    endfunction

endpackage

// File: rtl/lock_bank.sv
// Bank of hardware test-and-set spinlocks with two access ports.
//   clk, rst         : clock, asynchronous active-high reset (clears all locks)
//   enN              : port N performs a lock access at this edge
//   weN              : 1 = write (bit <= wbitN), 0 = test-and-set read
//   idxN             : lock index
//   wbitN            : value written by a lock write
//   qN               : registered old bit returned by the last test-and-set
// The arbiter never enables both ports on the same index in one cycle, so the
// two updates below never collide.
module lock_bank #(
    parameter int NLOCK = 16,
    parameter int LIW   = $clog2(NLOCK)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en0,
    input  logic           we0,
    input  logic [LIW-1:0] idx0,
    input  logic           wbit0,
    input  logic           en1,
    input  logic           we1,
    input  logic [LIW-1:0] idx1,
    input  logic           wbit1,
    output logic           q0,
    output logic           q1
);

    logic [NLOCK-1:0] bits;
    logic [NLOCK-1:0] bits_next;

    // A read sets the bit (test-and-set); a write stores wdata[0].
    always_comb begin
        bits_next = bits;
        if (en0)
            bits_next[idx0] = we0 ? wbit0 : 1'b1;
        if (en1)
            bits_next[idx1] = we1 ? wbit1 : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits <= '0;
            q0   <= 1'b0;
            q1   <= 1'b0;
        end else begin
            bits <= bits_next;
            if (en0 && !we0)
                q0 <= bits[idx0];
            if (en1 && !we1)
                q1 <= bits[idx1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between two cores and a true dual-port RAM.
// Core 0 drives RAM port A and core 1 drives RAM port B. Same-location hazards
// are serialized with round-robin priority. The window at LOCK_BASE holds
// NLOCK test-and-set spinlocks, and addresses above it form a void region.
//   clk, rst                   : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata       : core N request (held until granted)
//   pN_gnt                     : combinational grant, access at next edge
//   pN_rvalid/pN_rdata         : read response, one cycle after grant
//   ram_addr/we/wdata_a/b      : RAM port controls (combinational)
//   ram_q_a/b                  : RAM registered read data
//   conflict_cnt               : saturating count of serialized conflicts
//
// Handshake: a core raises pN_req with we/addr/wdata and holds all of them
// stable until it sees pN_gnt=1 in the same cycle. The access takes effect
// at that clock edge. A granted read returns pN_rdata with pN_rvalid=1 in the
// following cycle. A request seen with pN_gnt=0 is retried the next cycle.
module dmem_arbiter
    import kl_mem_pkg::*;
#(
    parameter int              AW        = kl_mem_pkg::AW,
    parameter int              DW        = kl_mem_pkg::DW,
    parameter int              NLOCK     = kl_mem_pkg::NLOCK,
    parameter logic [AW-1:0]   LOCK_BASE = kl_mem_pkg::LOCK_BASE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [7:0]    ram_addr_a,
    output logic          ram_we_a,
    output logic [DW-1:0] ram_wdata_a,
    input  logic [DW-1:0] ram_q_a,
    output logic [7:0]    ram_addr_b,
    output logic          ram_we_b,
    output logic [DW-1:0] ram_wdata_b,
    input  logic [DW-1:0] ram_q_b,
    output logic [15:0]   conflict_cnt
);

    localparam int LIW = $clog2(NLOCK);

    region_t        reg0, reg1;
    logic [LIW-1:0] lidx0, lidx1;
    logic           same_loc;
    logic           conflict;
    logic           prio;        // 0: core 0 wins a conflict
    region_t        src0, src1;  // source of the read in flight
    logic           lock_q0, lock_q1;

    always_comb begin
        reg0  = decode_region(p0_addr);
        reg1  = decode_region(p1_addr);
        lidx0 = LIW'(p0_addr - LOCK_BASE);
        lidx1 = LIW'(p1_addr - LOCK_BASE);
    end

    // The void region never conflicts. Two reads of one RAM word are harmless,
    // but every lock access modifies state, so two accesses to the same lock
    // always conflict.
    always_comb begin
        same_loc = ((reg0 == REG_RAM)  && (reg1 == REG_RAM)  &&
                    (p0_addr[7:0] == p1_addr[7:0])) ||
                   ((reg0 == REG_LOCK) && (reg1 == REG_LOCK) &&
                    (lidx0 == lidx1));
        conflict = p0_req && p1_req && same_loc &&
                   (p0_we || p1_we || (reg0 == REG_LOCK));
    end

    assign p0_gnt = p0_req && (!conflict || !prio);
    assign p1_gnt = p1_req && (!conflict ||  prio);

    assign ram_addr_a  = p0_addr[7:0];
    assign ram_addr_b  = p1_addr[7:0];
    assign ram_wdata_a = p0_wdata;
    assign ram_wdata_b = p1_wdata;
    assign ram_we_a    = p0_req && p0_we && p0_gnt && (reg0 == REG_RAM);
    assign ram_we_b    = p1_req && p1_we && p1_gnt && (reg1 == REG_RAM);

    lock_bank #(
        .NLOCK (NLOCK),
        .LIW   (LIW)
    ) u_lock_bank (
        .clk   (clk),
        .rst   (rst),
        .en0   (p0_gnt && (reg0 == REG_LOCK)),
        .we0   (p0_we),
        .idx0  (lidx0),
        .wbit0 (p0_wdata[0]),
        .en1   (p1_gnt && (reg1 == REG_LOCK)),
        .we1   (p1_we),
        .idx1  (lidx1),
        .wbit1 (p1_wdata[0]),
        .q0    (lock_q0),
        .q1    (lock_q1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid    <= 1'b0;
            p1_rvalid    <= 1'b0;
            src0         <= REG_RAM;
            src1         <= REG_RAM;
            prio         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            p0_rvalid <= p0_gnt && !p0_we;
            p1_rvalid <= p1_gnt && !p1_we;
            if (p0_gnt)
                src0 <= reg0;
            if (p1_gnt)
                src1 <= reg1;
            // Hand priority to this cycle's loser so it wins its retry.
            if (conflict) begin
                prio <= !prio;
                if (conflict_cnt != 16'hFFFF)
                    conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // Read data is forced to zero when no response is valid.
    always_comb begin
        p0_rdata = '0;
        if (p0_rvalid) begin
            case (src0)
                REG_RAM:  p0_rdata = ram_q_a;
                REG_LOCK: p0_rdata = {{(DW-1){1'b0}}, lock_q0};
                default:  p0_rdata = '0;
            endcase
        end
    end

    always_comb begin
        p1_rdata = '0;
        if (p1_rvalid) begin
            case (src1)
                REG_RAM:  p1_rdata = ram_q_b;
                REG_LOCK: p1_rdata = {{(DW-1){1'b0}}, lock_q1};
                default:  p1_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dual-port RAM model.
// While reset is high, RAM word i holds {8'hA5, i}.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [7:0]  ram_addr_a, ram_addr_b;
    logic        ram_we_a, ram_we_b;
    logic [15:0] ram_wdata_a, ram_wdata_b, ram_q_a, ram_q_b;
    logic [15:0] conflict_cnt;

    logic [15:0] mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    dmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .ram_addr_a   (ram_addr_a),
        .ram_we_a     (ram_we_a),
        .ram_wdata_a  (ram_wdata_a),
        .ram_q_a      (ram_q_a),
        .ram_addr_b   (ram_addr_b),
        .ram_we_b     (ram_we_b),
        .ram_wdata_b  (ram_wdata_b),
        .ram_q_b      (ram_q_b),
        .conflict_cnt (conflict_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read of the old contents, 1-cycle latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= {8'hA5, 8'(i)};
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
        end
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply the inputs just after the edge, then let them settle.
    task automatic drive(input logic r0, input logic w0, input logic [8:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1,
                         input logic [8:0] a1, input logic [15:0] d1);
        @(posedge clk);
        #1;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt0", p0_gnt, 0);
        check("rst_gnt1", p1_gnt, 0);
        check("rst_rvalid0", p0_rvalid, 0);
        check("rst_rvalid1", p1_rvalid, 0);
        check("rst_rdata0", p0_rdata, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_we_a", ram_we_a, 0);
        rst = 1'b0;

        // Core 0 writes 0x12, core 1 reads 0x34: no conflict.
        drive(1'b1, 1'b1, 9'h012, 16'hBEEF, 1'b1, 1'b0, 9'h034, 16'h0);
        check("t1_gnt0", p0_gnt, 1);
        check("t1_gnt1", p1_gnt, 1);
        check("t1_we_a", ram_we_a, 1);
        check("t1_we_b", ram_we_b, 0);
        check("t1_addr_b", ram_addr_b, 8'h34);
        idle();
        check("t1_rvalid1", p1_rvalid, 1);
        check("t1_rdata1", p1_rdata, 16'hA534);
        check("t1_rvalid0", p0_rvalid, 0);
        check("t1_mem12", mem[8'h12], 16'hBEEF);

        // Both write 0x20: core 0 wins, core 1 stalls one cycle.
        drive(1'b1, 1'b1, 9'h020, 16'h1111, 1'b1, 1'b1, 9'h020, 16'h2222);
        check("t2_gnt0", p0_gnt, 1);
        check("t2_gnt1", p1_gnt, 0);
        check("t2_we_b", ram_we_b, 0);
        drive(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b1, 9'h020, 16'h2222);
        check("t2_gnt1_retry", p1_gnt, 1);
        check("t2_mem20_first", mem[8'h20], 16'h1111);
        idle();
        check("t2_mem20_final", mem[8'h20], 16'h2222);
        check("t2_prio", dut.prio, 1);
        check("t2_cnt", conflict_cnt, 1);
        check("t2_rvalid1", p1_rvalid, 0);

        // Both test-and-set lock 0x103: prio=1, so core 1 wins.
        drive(1'b1, 1'b0, 9'h103, 16'h0, 1'b1, 1'b0, 9'h103, 16'h0);
        check("t3_gnt0", p0_gnt, 0);
        check("t3_gnt1", p1_gnt, 1);
        drive(1'b1, 1'b0, 9'h103, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0);
        check("t3_gnt0_retry", p0_gnt, 1);
        check("t3_rvalid1", p1_rvalid, 1);
        check("t3_rdata1", p1_rdata, 0);
        check("t3_rvalid0", p0_rvalid, 0);
        check("t3_cnt", conflict_cnt, 2);
        drive(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b1, 9'h103, 16'h0000);
        check("t3_rvalid0_b", p0_rvalid, 1);
        check("t3_rdata0", p0_rdata, 1);
        check("t3_clr_gnt1", p1_gnt, 1);
        drive(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b0, 9'h103, 16'h0);
        check("t3_wr_no_rvalid", p1_rvalid, 0);
        idle();
        check("t3_reread_rvalid", p1_rvalid, 1);
        check("t3_reread_rdata", p1_rdata, 0);

        // Both read RAM 0x40: no conflict.
        drive(1'b1, 1'b0, 9'h040, 16'h0, 1'b1, 1'b0, 9'h040, 16'h0);
        check("t4_gnt0", p0_gnt, 1);
        check("t4_gnt1", p1_gnt, 1);
        idle();
        check("t4_rdata0", p0_rdata, 16'hA540);
        check("t4_rdata1", p1_rdata, 16'hA540);
        check("t4_cnt", conflict_cnt, 2);

        // Void region: read returns 0, write is dropped.
        drive(1'b1, 1'b0, 9'h1F0, 16'h0, 1'b1, 1'b1, 9'h1F0, 16'hDEAD);
        check("t5_gnt0", p0_gnt, 1);
        check("t5_gnt1", p1_gnt, 1);
        check("t5_we_a", ram_we_a, 0);
        check("t5_we_b", ram_we_b, 0);
        idle();
        check("t5_rvalid0", p0_rvalid, 1);
        check("t5_rdata0", p0_rdata, 0);
        check("t5_rvalid1", p1_rvalid, 0);
        check("t5_memF0", mem[8'hF0], 16'hA5F0);

        // Set lock 5, then reset while core 1 is stalled.
        drive(1'b1, 1'b0, 9'h105, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0);
        check("t6_gnt0", p0_gnt, 1);
        drive(1'b1, 1'b1, 9'h050, 16'hAAAA, 1'b1, 1'b1, 9'h050, 16'hBBBB);
        check("t6_stall_gnt1", p1_gnt, 0);
        check("t6_pre_rvalid0", p0_rvalid, 1);
        check("t6_pre_rdata0", p0_rdata, 0);
        check("t6_pre_cnt", conflict_cnt, 2);
        p0_req = 1'b0;
        p1_req = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid0", p0_rvalid, 0);
        check("t6_rst_rvalid1", p1_rvalid, 0);
        check("t6_rst_cnt", conflict_cnt, 0);
        check("t6_rst_prio", dut.prio, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b0, 9'h105, 16'h0);
        check("t6_gnt1", p1_gnt, 1);
        idle();
        check("t6_lock_rvalid1", p1_rvalid, 1);
        check("t6_lock_rdata1", p1_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
